pc_fetch_ctrl: RTL and testbench

//  Program-counter register and instruction-fetch sequencer sitting on both sides of the 32-bit

---
 rtl/pc_fetch_ctrl_pkg.sv | 23 ++
 rtl/pc_fetch_ctrl_if.sv | 31 +++
 rtl/pc_fetch_ctrl_pc_adder32.sv | 17 +
 rtl/pc_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_pkg
//   Shared definitions for the program-counter / fetch sequencer:
//   fetch FSM state encodings, PC step size, default reset PC and a
//   word-alignment helper.
// ---------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,   // one idle cycle after reset release
        FS_FETCH = 2'd1,   // normal fetching
        FS_DROP  = 2'd2    // finishing a fetch whose data must be thrown away
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned; the low two address bits are forced to 0.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
//   Instruction-memory fetch bus (req/ready handshake).
//   mem_req   : fetch request, held with mem_addr until mem_ready
//   mem_addr  : word address of the fetch
//   mem_ready : fetch complete, mem_rdata valid this cycle
//   mem_rdata : fetched instruction word
//   master = fetch controller, slave = instruction memory.
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/pc_fetch_ctrl_pc_adder32.sv
// ---------------------------------------------------------------------------
// pc_adder32
//   32-bit +4 incrementer feeding input a of the external next-PC mux.
//   pc       in  32  current program counter
//   pc_plus4 out 32  pc + 4, wrapping modulo 2^32
// ---------------------------------------------------------------------------
module pc_adder32
    import pc_fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    // Carry out of bit 31 is dropped, so 0xFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc + PC_STEP;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter register and instruction-fetch sequencer. Issues word
//   fetches over a req/ready bus and holds the returned word in a one-entry
//   buffer for the decode stage. The next-PC mux is external: pc_plus4 goes
//   out to its input a, and its output returns as next_pc (flush is its
//   select).
//
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   next_pc      in   32  next-PC mux output ([1:0] ignored)
//   flush        in   1   redirect from execute
//   pc_plus4     out  32  pc + 4
//   mem          master   fetch bus (mem_req/mem_addr/mem_ready/mem_rdata)
//   instr        out  32  buffered instruction
//   instr_pc     out  32  address of buffered instruction
//   instr_valid  out  1   buffer holds a valid instruction
//   instr_ready  in   1   downstream consumes the buffer this cycle
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            next_pc,
    input  logic                   flush,
    output logic [31:0]            pc_plus4,
    pc_fetch_ctrl_if.master        mem,
    output logic [31:0]            instr,
    output logic [31:0]            instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         req_active;   // request issued and not yet answered
    logic [31:0]  req_addr;     // address held while a request is outstanding

    logic         buf_free;
    logic         req_c;
    logic [31:0]  addr_c;
    logic         completion;

    pc_adder32 u_pc_adder32 (
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    // Request/address decode. Once a request has been seen without
    // mem_ready, req_active keeps it asserted at req_addr even if the
    // buffer stops being free, so the bus never withdraws a request.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        buf_free = !instr_valid || instr_ready;
        req_c    = 1'b0;
        addr_c   = pc;
        case (state)
            FS_FETCH: begin
                req_c  = req_active || buf_free;
                addr_c = req_active ? req_addr : pc;
            end
            FS_DROP: begin
                req_c  = 1'b1;
                addr_c = req_addr;
            end
            default: begin
                req_c  = 1'b0;
                addr_c = pc;
            end
        endcase
    end

    assign completion   = (state == FS_FETCH) && req_c && mem.mem_ready;
    assign mem.mem_req  = req_c;
    assign mem.mem_addr = addr_c;

    // NOTE: non-blocking assignments for all registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FS_BOOT;
            pc          <= word_align(RESET_PC);
            req_active  <= 1'b0;
            req_addr    <= 32'h0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
        end else if (flush) begin
            // Redirect wins over everything: any returning data is dropped.
            pc          <= word_align(next_pc);
            instr_valid <= 1'b0;
            req_active  <= 1'b0;
            case (state)
                FS_FETCH: begin
                    if (req_c && !mem.mem_ready) begin
                        // The bus must still finish this request; park in DROP.
                        state    <= FS_DROP;
                        req_addr <= addr_c;
                    end else begin
                        state <= FS_FETCH;
                    end
                end
                // A second redirect keeps draining; leave only once answered.
                FS_DROP: state <= mem.mem_ready ? FS_FETCH : FS_DROP;
                default: state <= FS_FETCH;
            endcase
        end else begin
            case (state)
                FS_BOOT: state <= FS_FETCH;
                FS_FETCH: begin
                    if (completion) begin
                        instr       <= mem.mem_rdata;
                        instr_pc    <= addr_c;
                        instr_valid <= 1'b1;
                        pc          <= word_align(next_pc);
                        req_active  <= 1'b0;
                    end else if (req_c && !req_active) begin
                        req_active <= 1'b1;
                        req_addr   <= pc;
                    end
                end
                FS_DROP: begin
                    if (mem.mem_ready) begin
                        state <= FS_FETCH;
                    end
                end
                default: state <= FS_BOOT;
            endcase
            if (instr_valid && instr_ready && !completion) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Self-checking bench for pc_fetch_ctrl. A memory model answers fetches
//   after a programmable number of wait cycles with a data word derived from
//   the address. The reference model is the program order itself: every
//   instruction taken downstream must be the next sequential address since
//   the last redirect, carrying that address's memory word.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] target;
    logic        flush;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    pc_fetch_ctrl_if mem_if ();

    always #5 clk = ~clk;

    // External next-PC mux: a = pc_plus4, b = target, s = flush.
    assign next_pc = flush ? target : pc_plus4;

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .flush       (flush),
        .pc_plus4    (pc_plus4),
        .mem         (mem_if),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    int total = 0;
    int bad   = 0;

    // Stimulus settings applied at the next step.
    logic        drv_ir;
    logic        drv_fl;
    logic [31:0] drv_tgt;
    int          mem_lat;

    // Memory model and reference state.
    logic        in_req;
    int          remain;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic [31:0] exp_pc;
    int          consumed;

    // Values sampled just before the active edge of the last step.
    logic        s_req, s_ready, s_valid;
    logic [31:0] s_addr, s_ipc, s_instr, s_plus4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic reset_model();
        in_req    = 1'b0;
        remain    = 0;
        prev_pend = 1'b0;
        prev_addr = 32'h0;
        exp_pc    = RST_PC;
        mem_if.mem_ready = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, answer the bus, sample,
    // run the protocol/order monitor, then pass the rising edge.
    task automatic step();
        @(negedge clk);
        instr_ready = drv_ir;
        flush       = drv_fl;
        target      = drv_tgt;
        #1;
        if (mem_if.mem_req && !in_req) begin
            in_req = 1'b1;
            remain = mem_lat;
        end
        mem_if.mem_ready = mem_if.mem_req && (remain == 0);
        mem_if.mem_rdata = mem_if.mem_ready ? mem_word(mem_if.mem_addr) : $urandom();
        #1;
        s_req   = mem_if.mem_req;
        s_ready = mem_if.mem_ready;
        s_addr  = mem_if.mem_addr;
        s_valid = instr_valid;
        s_ipc   = instr_pc;
        s_instr = instr;
        s_plus4 = pc_plus4;
        if (prev_pend) begin
            total++;
            if (s_req !== 1'b1 || s_addr !== prev_addr) begin
                bad++;
                $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", s_req, s_addr, prev_addr);
            end
        end
        if (s_valid === 1'b1 && drv_ir) begin
            total++;
            if (s_ipc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
                bad++;
                $display("FAIL order: instr_pc=%h instr=%h, required instr_pc=%h instr=%h",
                         s_ipc, s_instr, exp_pc, mem_word(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (drv_fl) exp_pc = drv_tgt & ~32'h3;
        prev_pend = s_req && !s_ready;
        prev_addr = s_addr;
        @(posedge clk);
        if (s_req && s_ready) in_req = 1'b0;
        else if (in_req && remain > 0) remain--;
    endtask

    // Drain any outstanding fetch with a zero-wait memory.
    task automatic settle();
        drv_ir  = 1'b1;
        drv_fl  = 1'b0;
        mem_lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!in_req) return;
        end
        total++;
        bad++;
        $display("FAIL settle_timeout: fetch still outstanding after 20 cycles, required idle");
    endtask

    task automatic redirect(input logic [31:0] t);
        settle();
        drv_fl  = 1'b1;
        drv_tgt = t;
        step();
        drv_fl  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drv_ir = 1'b1; drv_fl = 1'b0; drv_tgt = 32'h0; mem_lat = 0;
        instr_ready = 1'b1; flush = 1'b0; target = 32'h0;
        mem_if.mem_rdata = 32'h0;
        reset_model();
        consumed = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (mem_if.mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_mem_req: got %b required 0", mem_if.mem_req);
        end
        total++;
        if (instr_valid !== 1'b0) begin
            bad++; $display("FAIL reset_instr_valid: got %b required 0", instr_valid);
        end
        total++;
        if (mem_if.mem_addr !== RST_PC) begin
            bad++; $display("FAIL reset_mem_addr: got %h required %h", mem_if.mem_addr, RST_PC);
        end
        total++;
        if (pc_plus4 !== RST_PC + 32'd4) begin
            bad++; $display("FAIL reset_pc_plus4: got %h required %h", pc_plus4, RST_PC + 32'd4);
        end
        total++;
        if (instr !== 32'h0 || instr_pc !== 32'h0) begin
            bad++; $display("FAIL reset_instr: got %h/%h required 0/0", instr, instr_pc);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        total++;
        if (s_req !== 1'b0) begin
            bad++; $display("FAIL boot_no_req: got %b required 0", s_req);
        end
    endtask

    task automatic test_stream();
        drv_ir = 1'b1; mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (s_req !== 1'b1 || s_addr !== RST_PC + 32'(4 * i)) begin
                bad++; $display("FAIL stream_addr%0d: req=%b addr=%h required 1/%h", i, s_req, s_addr, RST_PC + 32'(4 * i));
            end
            if (i > 0) begin
                total++;
                if (s_valid !== 1'b1 || s_ipc !== RST_PC + 32'(4 * (i - 1))) begin
                    bad++; $display("FAIL stream_ipc%0d: valid=%b ipc=%h required 1/%h", i, s_valid, s_ipc, RST_PC + 32'(4 * (i - 1)));
                end
            end
        end
        step();
        total++;
        if (s_valid !== 1'b1 || s_ipc !== RST_PC + 32'hC) begin
            bad++; $display("FAIL stream_ipc4: valid=%b ipc=%h required 1/%h", s_valid, s_ipc, RST_PC + 32'hC);
        end
    endtask

    task automatic test_wait_states();
        redirect(32'h100);
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (s_req !== 1'b1 || s_addr !== 32'h100 || s_ready !== (i == 2) || s_valid !== 1'b0) begin
                bad++; $display("FAIL wait_cycle%0d: req=%b addr=%h ready=%b valid=%b required 1/100/%b/0",
                                i, s_req, s_addr, s_ready, s_valid, (i == 2));
            end
        end
        drv_ir = 1'b0;
        step();
        total++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h100 || s_addr !== 32'h104) begin
            bad++; $display("FAIL wait_result: valid=%b ipc=%h pc=%h required 1/100/104", s_valid, s_ipc, s_addr);
        end
    endtask

    task automatic test_backpressure();
        drv_ir = 1'b0; mem_lat = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (s_req !== 1'b0 || s_valid !== 1'b1 || s_ipc !== 32'h100) begin
                bad++; $display("FAIL bp_hold%0d: req=%b valid=%b ipc=%h required 0/1/100", i, s_req, s_valid, s_ipc);
            end
        end
        drv_ir = 1'b1;
        step();
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h104) begin
            bad++; $display("FAIL bp_release: req=%b addr=%h required 1/104", s_req, s_addr);
        end
        step();
        total++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h104) begin
            bad++; $display("FAIL bp_next: valid=%b ipc=%h required 1/104", s_valid, s_ipc);
        end
    endtask

    task automatic test_flush_drop();
        redirect(32'h40);
        mem_lat = 2;
        step();
        drv_fl = 1'b1; drv_tgt = 32'h2000;
        step();
        drv_fl = 1'b0; mem_lat = 0;
        step();
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h40 || s_ready !== 1'b1 || s_valid !== 1'b0) begin
            bad++; $display("FAIL drop_hold: req=%b addr=%h ready=%b valid=%b required 1/40/1/0", s_req, s_addr, s_ready, s_valid);
        end
        step();
        total++;
        if (s_req !== 1'b1 || s_addr !== 32'h2000 || s_valid !== 1'b0) begin
            bad++; $display("FAIL drop_next: req=%b addr=%h valid=%b required 1/2000/0", s_req, s_addr, s_valid);
        end
        step();
        total++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h2000) begin
            bad++; $display("FAIL drop_deliver: valid=%b ipc=%h required 1/2000", s_valid, s_ipc);
        end
    endtask

    task automatic test_flush_on_complete();
        redirect(32'h80);
        mem_lat = 1;
        step();
        drv_fl = 1'b1; drv_tgt = 32'h300;
        step();
        total++;
        if (s_ready !== 1'b1 || s_addr !== 32'h80) begin
            bad++; $display("FAIL fc_complete: ready=%b addr=%h required 1/80", s_ready, s_addr);
        end
        drv_fl = 1'b0; mem_lat = 0;
        step();
        total++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h300) begin
            bad++; $display("FAIL fc_next: valid=%b req=%b addr=%h required 0/1/300", s_valid, s_req, s_addr);
        end
        step();
        total++;
        if (s_valid !== 1'b1 || s_ipc !== 32'h300) begin
            bad++; $display("FAIL fc_deliver: valid=%b ipc=%h required 1/300", s_valid, s_ipc);
        end
    endtask

    task automatic test_wrap_reset();
        redirect(32'hFFFF_FFFC);
        mem_lat = 0;
        step();
        total++;
        if (s_plus4 !== 32'h0 || s_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_plus4: plus4=%h addr=%h required 0/fffffffc", s_plus4, s_addr);
        end
        mem_lat = 3;
        step();
        total++;
        if (s_addr !== 32'h0 || s_ready !== 1'b0 || s_plus4 !== 32'h4) begin
            bad++; $display("FAIL wrap_addr: addr=%h ready=%b plus4=%h required 0/0/4", s_addr, s_ready, s_plus4);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (mem_if.mem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL async_rst: req=%b valid=%b required 0/0", mem_if.mem_req, instr_valid);
        end
        total++;
        if (mem_if.mem_addr !== RST_PC || pc_plus4 !== RST_PC + 32'd4) begin
            bad++; $display("FAIL async_rst_pc: addr=%h plus4=%h required %h/%h", mem_if.mem_addr, pc_plus4, RST_PC, RST_PC + 32'd4);
        end
        reset_model();
        mem_lat = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        total++;
        if (s_req !== 1'b0) begin
            bad++; $display("FAIL rst_boot: req=%b required 0", s_req);
        end
        step();
        total++;
        if (s_req !== 1'b1 || s_addr !== RST_PC) begin
            bad++; $display("FAIL rst_refetch: req=%b addr=%h required 1/%h", s_req, s_addr, RST_PC);
        end
    endtask

    task automatic test_random();
        int start;
        start = consumed;
        for (int i = 0; i < 3000; i++) begin
            drv_ir  = ($urandom_range(9, 0) < 7);
            drv_fl  = ($urandom_range(19, 0) == 0);
            drv_tgt = $urandom();
            mem_lat = $urandom_range(3, 0);
            step();
        end
        drv_fl = 1'b0;
        total++;
        if (consumed - start < 200) begin
            bad++; $display("FAIL random_progress: consumed %0d required at least 200", consumed - start);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_backpressure();
        test_flush_drop();
        test_flush_on_complete();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
